// File: rtl/blk_enc_128b130b.sv
// Transmit 128b/130b block encoder: scrambles data payloads with the 23-bit PHY LFSR,
// prepends the sync header and holds one registered block for a valid/ready sink.
module blk_enc_128b130b #(
    parameter int          PAY_W = 128,
    parameter logic [22:0] SEED  = 23'h1DBFBC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PAY_W-1:0]   in_data,
    input  logic               in_ctrl,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               scr_init,
    input  logic               scr_en,
    output logic [PAY_W+1:0]   out_block,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        blk_cnt
);
    localparam logic [1:0] HDR_DATA = 2'b10;
    localparam logic [1:0] HDR_CTRL = 2'b01;

    logic               r_out_valid;
    logic [PAY_W+1:0]   r_out_block;
    logic [15:0]        r_blk_cnt;
    logic [22:0]        r_lfsr;

    logic               w_accept;
    logic               w_transfer;
    logic [22:0]        w_scr_state;
    logic [22:0]        w_lfsr_next;
    logic [PAY_W-1:0]   w_scr_pay;
    logic [PAY_W-1:0]   w_payload;
    logic [1:0]         w_hdr;

    // Runs the LFSR PAY_W steps; returns {final state, scrambled payload}.
    function automatic logic [PAY_W+22:0] f_scramble(input logic [22:0]      state_in,
                                                     input logic [PAY_W-1:0] pay_in);
        logic [22:0]      st;
        logic [PAY_W-1:0] sp;
        logic             fb;
        st = state_in;
        sp = pay_in;
        for (int i = 0; i < PAY_W; i++) begin
            sp[i] = pay_in[i] ^ st[22];
            fb    = st[22] ^ st[20] ^ st[15] ^ st[7] ^ st[4] ^ st[1];
            st    = {st[21:0], fb};
        end
        return {st, sp};
    endfunction

    // Handshake decode and next-block datapath; scr_init makes the current block use SEED.
    always_comb begin
        in_ready    = ~r_out_valid | out_ready;
        w_accept    = in_valid & in_ready;
        w_transfer  = r_out_valid & out_ready;
        w_scr_state = scr_init ? SEED : r_lfsr;
        {w_lfsr_next, w_scr_pay} = f_scramble(w_scr_state, in_data);
        if (in_ctrl || !scr_en) begin
            w_payload = in_data;
        end else begin
            w_payload = w_scr_pay;
        end
        if (in_ctrl) begin
            w_hdr = HDR_CTRL;
        end else begin
            w_hdr = HDR_DATA;
        end
    end

    // Single output register stage: load on accept, empty on transfer without accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_block <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_block <= {w_payload, w_hdr};
        end else if (w_transfer) begin
            r_out_valid <= 1'b0;
        end
    end

    // Scrambler state: reload wins over the per-data-block advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else if (scr_init) begin
            r_lfsr <= SEED;
        end else if (w_accept && !in_ctrl) begin
            r_lfsr <= w_lfsr_next;
        end
    end

    // Transferred-block counter, free-running 16-bit wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk_cnt <= 16'd0;
        end else if (w_transfer) begin
            r_blk_cnt <= r_blk_cnt + 16'd1;
        end
    end

    assign out_block = r_out_block;
    assign out_valid = r_out_valid;
    assign blk_cnt   = r_blk_cnt;

endmodule
